// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run controller for the 16-bit single-cycle MIPS core.
// Holds the core in reset, runs it for a bounded number of cycles, and
// detects a halted program when the PC stops moving. Every ALU result is
// folded into a rolling signature so that a run can be judged pass or fail.
module mips_run_ctrl #(
  parameter int unsigned PC_W         = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned RESET_CYCLES = 5,
  parameter int unsigned MAX_CYCLES   = 45,
  parameter int unsigned STALL_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [PC_W-1:0]   i_pc_in,
  input  logic [DATA_W-1:0] i_alu_in,
  output logic              o_cpu_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_halted,
  output logic              o_timed_out,
  output logic [CNT_W-1:0]  o_cycle_count,
  output logic [DATA_W-1:0] o_signature,
  output logic [PC_W-1:0]   o_last_pc
);

  // The hold counter runs 0..RESET_CYCLES-1; the stall counter runs 0..STALL_CYCLES.
  localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [STALL_W-1:0]  r_stall_cnt;
  logic                r_cpu_reset;
  logic                r_busy;
  logic                r_done;
  logic                r_halted;
  logic                r_timed_out;
  logic [CNT_W-1:0]    r_cycle_count;
  logic [DATA_W-1:0]   r_signature;
  logic [PC_W-1:0]     r_last_pc;

  logic                w_first_run;
  logic                w_pc_same;
  logic [CNT_W-1:0]    w_cycle_next;
  logic [DATA_W-1:0]   w_sig_next;
  logic [STALL_W-1:0]  w_stall_next;
  logic                w_halt;
  logic                w_timeout;
  logic                w_hold_last;

  // Cycle count is cleared on every start, so zero marks the first RUN cycle.
  assign w_first_run  = (r_cycle_count == '0);
  assign w_pc_same    = (i_pc_in == r_last_pc);
  assign w_cycle_next = r_cycle_count + CNT_W'(1);
  assign w_sig_next   = {r_signature[DATA_W-2:0], r_signature[DATA_W-1]} ^ i_alu_in;
  assign w_stall_next = w_first_run ? '0 :
                        (w_pc_same ? (r_stall_cnt + STALL_W'(1)) : '0);

  // Termination tests look at the values this RUN cycle is about to commit.
  assign w_halt      = (w_stall_next == STALL_W'(STALL_CYCLES));
  assign w_timeout   = (w_cycle_next == CNT_W'(MAX_CYCLES));
  assign w_hold_last = (r_hold_cnt == HOLD_W'(RESET_CYCLES - 1));

  // Run sequencer: state, counters, signature and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_hold_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_cpu_reset   <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_halted      <= 1'b0;
      r_timed_out   <= 1'b0;
      r_cycle_count <= '0;
      r_signature   <= '0;
      r_last_pc     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A new run clears the results of the previous one; last_pc is kept.
          if (i_start) begin
            r_state       <= S_HOLD;
            r_hold_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_cpu_reset   <= 1'b1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_halted      <= 1'b0;
            r_timed_out   <= 1'b0;
            r_cycle_count <= '0;
            r_signature   <= '0;
          end
        end

        S_HOLD: begin
          if (w_hold_last) begin
            r_state     <= S_RUN;
            r_cpu_reset <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end

        S_RUN: begin
          r_cycle_count <= w_cycle_next;
          r_signature   <= w_sig_next;
          r_last_pc     <= i_pc_in;
          r_stall_cnt   <= w_stall_next;
          // A halt wins over a timeout landing on the same cycle.
          if (w_halt || w_timeout) begin
            r_state     <= S_DONE;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_halted    <= w_halt;
            r_timed_out <= w_timeout & ~w_halt;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cpu_reset   = r_cpu_reset;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_halted      = r_halted;
  assign o_timed_out   = r_timed_out;
  assign o_cycle_count = r_cycle_count;
  assign o_signature   = r_signature;
  assign o_last_pc     = r_last_pc;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a default instance plus a short-budget instance
// (MAX_CYCLES=5) for the halt/timeout priority case, both compared every
// cycle against a timeline model, plus hand-computed literal checks.
module tb_mips_run_ctrl;

  localparam int RC   = 5;
  localparam int MAXD = 45;
  localparam int MAXP = 5;
  localparam int STL  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st0;
  logic        st1;
  logic [15:0] pc;
  logic [15:0] alu;

  logic        o0_cpu_reset, o0_busy, o0_done, o0_halted, o0_timed_out;
  logic [15:0] o0_cc, o0_sig, o0_lpc;
  logic        o1_cpu_reset, o1_busy, o1_done, o1_halted, o1_timed_out;
  logic [15:0] o1_cc, o1_sig, o1_lpc;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int low_cnt;

  always #5 clk = ~clk;

  mips_run_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_start(st0), .i_pc_in(pc), .i_alu_in(alu),
    .o_cpu_reset(o0_cpu_reset), .o_busy(o0_busy), .o_done(o0_done),
    .o_halted(o0_halted), .o_timed_out(o0_timed_out),
    .o_cycle_count(o0_cc), .o_signature(o0_sig), .o_last_pc(o0_lpc)
  );

  mips_run_ctrl #(.MAX_CYCLES(MAXP)) dut_p (
    .i_clk(clk), .i_reset(rst), .i_start(st1), .i_pc_in(pc), .i_alu_in(alu),
    .o_cpu_reset(o1_cpu_reset), .o_busy(o1_busy), .o_done(o1_done),
    .o_halted(o1_halted), .o_timed_out(o1_timed_out),
    .o_cycle_count(o1_cc), .o_signature(o1_sig), .o_last_pc(o1_lpc)
  );

  // Model: a run is a timeline measured in edges since the accepted start.
  // Edges 1..RC hold the core; every later edge is one RUN sample.
  typedef struct {
    bit          active;
    int          t;
    bit          done;
    bit          halted;
    bit          tmo;
    int          cc;
    logic [15:0] sig;
    logic [15:0] pc;
    int          stall;
  } model_t;

  model_t m0;
  model_t m1;

  function automatic model_t model_step(input model_t m, input int rc, input int mx,
                                        input int stl, input bit r, input bit s,
                                        input logic [15:0] p, input logic [15:0] a);
    model_t n;
    int k;
    n = m;
    if (r) begin
      n.active = 0; n.t = 0; n.done = 0; n.halted = 0; n.tmo = 0;
      n.cc = 0; n.sig = 16'h0; n.pc = 16'h0; n.stall = 0;
      return n;
    end
    if (m.active) begin
      n.t = m.t + 1;
      if (n.t > rc) begin
        k = n.t - rc;
        n.cc = k;
        n.sig = ((m.sig << 1) | (m.sig >> 15)) ^ a;
        n.stall = (k == 1) ? 0 : ((p == m.pc) ? m.stall + 1 : 0);
        n.pc = p;
        if (n.stall >= stl) begin
          n.active = 0; n.done = 1; n.halted = 1;
        end else if (k >= mx) begin
          n.active = 0; n.done = 1; n.tmo = 1;
        end
      end
    end else if (s) begin
      n.active = 1; n.t = 0; n.done = 0; n.halted = 0; n.tmo = 0;
      n.cc = 0; n.sig = 16'h0; n.stall = 0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 <= model_step(m0, RC, MAXD, STL, rst, st0, pc, alu);
    m1 <= model_step(m1, RC, MAXP, STL, rst, st1, pc, alu);
  end

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input model_t m, input logic cr, input logic bz,
                           input logic dn, input logic hl, input logic to,
                           input logic [15:0] cc, input logic [15:0] sg, input logic [15:0] lp);
    cmp({tag, ".cpu_reset"}, 16'(cr), 16'(!(m.active && m.t >= RC)));
    cmp({tag, ".busy"},      16'(bz), 16'(m.active));
    cmp({tag, ".done"},      16'(dn), 16'(m.done));
    cmp({tag, ".halted"},    16'(hl), 16'(m.halted));
    cmp({tag, ".timed_out"}, 16'(to), 16'(m.tmo));
    cmp({tag, ".cycle_count"}, cc, 16'(m.cc));
    cmp({tag, ".signature"}, sg, m.sig);
    cmp({tag, ".last_pc"},   lp, m.pc);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_all("m0", m0, o0_cpu_reset, o0_busy, o0_done, o0_halted, o0_timed_out,
                o0_cc, o0_sig, o0_lpc);
      check_all("m1", m1, o1_cpu_reset, o1_busy, o1_done, o1_halted, o1_timed_out,
                o1_cc, o1_sig, o1_lpc);
    end
  end

  // Pulse start for one edge, then wait out the reset hold.
  task automatic start_run(input bit which);
    if (which) st1 = 1'b1; else st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    st1 = 1'b0;
    cmp("start.busy",      16'(which ? o1_busy : o0_busy), 16'h1);
    cmp("start.cpu_reset", 16'(which ? o1_cpu_reset : o0_cpu_reset), 16'h1);
    cmp("start.cc_clear",  which ? o1_cc : o0_cc, 16'h0);
    cmp("start.flags",     16'({which ? o1_halted : o0_halted, which ? o1_timed_out : o0_timed_out,
                                which ? o1_done : o0_done}), 16'h0);
    repeat (RC) @(negedge clk);
    cmp("hold.release",    16'(which ? o1_cpu_reset : o0_cpu_reset), 16'h0);
  endtask

  task automatic run_cycle(input logic [15:0] p, input logic [15:0] a);
    pc  = p;
    alu = a;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; st0 = 1'b1; st1 = 1'b1; pc = 16'h0; alu = 16'h0;

    // Reset held 3 cycles with start asserted: start must be ignored.
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    cmp("rst.cpu_reset", 16'(o0_cpu_reset), 16'h1);
    cmp("rst.busy",      16'(o0_busy), 16'h0);
    cmp("rst.cc",        o0_cc, 16'h0);
    cmp("rst.sig",       o0_sig, 16'h0);
    rst = 1'b0; st0 = 1'b0; st1 = 1'b0;
    @(negedge clk);

    // Timeout: PC advances every cycle, ALU quiet.
    start_run(1'b0);
    low_cnt = 1;
    for (int k = 1; k <= MAXD; k++) begin
      run_cycle(16'(2 * (k - 1)), 16'h0);
      if (o0_cpu_reset == 1'b0) low_cnt++;
    end
    cmp("tmo.low_cycles", 16'(low_cnt), 16'd45);
    cmp("tmo.done",       16'(o0_done), 16'h1);
    cmp("tmo.timed_out",  16'(o0_timed_out), 16'h1);
    cmp("tmo.halted",     16'(o0_halted), 16'h0);
    cmp("tmo.cc",         o0_cc, 16'd45);
    cmp("tmo.sig",        o0_sig, 16'h0000);
    repeat (2) @(negedge clk);
    cmp("tmo.hold_cc",    o0_cc, 16'd45);

    // Halt, restarted straight from DONE.
    start_run(1'b0);
    for (int k = 1; k <= 15; k++) begin
      run_cycle((k <= 10) ? 16'(2 * (k - 1)) : 16'd20, 16'h0);
    end
    cmp("halt.done",      16'(o0_done), 16'h1);
    cmp("halt.halted",    16'(o0_halted), 16'h1);
    cmp("halt.timed_out", 16'(o0_timed_out), 16'h0);
    cmp("halt.cc",        o0_cc, 16'd15);
    cmp("halt.last_pc",   o0_lpc, 16'h0014);

    // Signature accumulation, start ignored mid-run, then abort by reset.
    start_run(1'b0);
    run_cycle(16'd0, 16'h0001);
    cmp("sig.c1", o0_sig, 16'h0001);
    run_cycle(16'd2, 16'h0001);
    cmp("sig.c2", o0_sig, 16'h0003);
    run_cycle(16'd4, 16'h0001);
    cmp("sig.c3", o0_sig, 16'h0007);
    st0 = 1'b1;
    run_cycle(16'd6, 16'h0000);
    st0 = 1'b0;
    cmp("run.start_ign_busy", 16'(o0_busy), 16'h1);
    cmp("run.start_ign_cc",   o0_cc, 16'd4);
    cmp("run.sig_c4",         o0_sig, 16'h000E);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("abort.cpu_reset", 16'(o0_cpu_reset), 16'h1);
    cmp("abort.busy",      16'(o0_busy), 16'h0);
    cmp("abort.cc",        o0_cc, 16'h0);
    cmp("abort.sig",       o0_sig, 16'h0);
    cmp("abort.last_pc",   o0_lpc, 16'h0);
    @(negedge clk);

    // Rotate wrap of the top signature bit.
    start_run(1'b0);
    run_cycle(16'd0, 16'h8000);
    cmp("wrap.c1", o0_sig, 16'h8000);
    run_cycle(16'd2, 16'h8000);
    cmp("wrap.c2", o0_sig, 16'h8001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Halt and timeout on the same cycle: halt wins.
    start_run(1'b1);
    for (int k = 1; k <= MAXP; k++) run_cycle(16'h0040, 16'h0000);
    cmp("prio.done",      16'(o1_done), 16'h1);
    cmp("prio.halted",    16'(o1_halted), 16'h1);
    cmp("prio.timed_out", 16'(o1_timed_out), 16'h0);
    cmp("prio.cc",        o1_cc, 16'd5);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
